// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types and constants for the boot sequencer: FSM state
//                encoding (which doubles as the external mode value), fetch
//                source select values and the default HD image location.
//  Revision    : 1.0  initial release
// ============================================================================
package boot_pkg;

  // State encoding is exported directly on the mode port.
  typedef enum logic [2:0] {
    BOOT_BIOS    = 3'd0,
    BOOT_HDR     = 3'd1,
    BOOT_COPY    = 3'd2,
    BOOT_RESTART = 3'd3,
    BOOT_PROG    = 3'd4,
    BOOT_HALTED  = 3'd5
  } boot_state_t;

  // Fetch source select values.
  localparam logic SRC_BIOS = 1'b0;
  localparam logic SRC_PROG = 1'b1;

  // Default HD word address of the image header.
  localparam int unsigned c_hd_base_default = 0;

endpackage : boot_pkg
`default_nettype wire

// File: rtl/boot_ctrl_hd_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : hd_copy_engine
//  Description : Owns the HD req/ack handshake (header read and image words),
//                the word counter and the instruction-memory write strobe.
//                Each accepted image word is written one cycle after its ack;
//                the next request is launched from that write cycle, leaving
//                at least one idle cycle between request pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module hd_copy_engine
  import boot_pkg::*;
#(
  parameter int unsigned    AW      = 32,
  parameter int unsigned    CW      = 11,
  parameter logic [AW-1:0]  HD_BASE = AW'(c_hd_base_default)
) (
  input  logic          clk_auto,
  input  logic          reset_n,
  input  logic          hdr_fetch,   // issue header read at HD_BASE
  input  logic          start,       // begin copying len words
  input  logic [CW-1:0] len,
  output logic          done,        // pulse with the final image write
  output logic          busy,
  output logic          ack_ok,      // ack accepted this cycle (req was high)
  output logic          hd_req,
  output logic [AW-1:0] hd_addr,
  input  logic          hd_ack,
  input  logic [31:0]   hd_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata
);

  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_issue;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;

  logic          w_ack;
  logic [CW-1:0] w_cnt_inc;
  logic          w_more;

  assign w_ack     = r_req & hd_ack;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_more    = (w_cnt_inc < r_len);

  // Handshake, counter and write strobe sequencing.
  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_issue <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (hdr_fetch) begin
        r_req  <= 1'b1;
        r_addr <= HD_BASE;
      end else if (w_ack) begin
        // Request drops the cycle after ack; image words are written then.
        r_req <= 1'b0;
        if (r_busy) begin
          r_we    <= 1'b1;
          r_waddr <= AW'(r_cnt);
          r_wdata <= hd_data;
        end
      end else if (r_issue) begin
        // First image word, one idle cycle after the header ack.
        r_req   <= 1'b1;
        r_addr  <= HD_BASE + AW'(1);
        r_issue <= 1'b0;
      end else if (r_we) begin
        r_cnt <= w_cnt_inc;
        if (w_more) begin
          r_req  <= 1'b1;
          r_addr <= HD_BASE + AW'(2) + AW'(r_cnt);
        end else begin
          r_busy <= 1'b0;
        end
      end
      // Start coincides with the header ack; it only primes the copy.
      if (start) begin
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_len   <= len;
        r_issue <= 1'b1;
      end
    end
  end

  assign done       = r_we & ~w_more;
  assign busy       = r_busy;
  assign ack_ok     = w_ack;
  assign hd_req     = r_req;
  assign hd_addr    = r_addr;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;

endmodule : hd_copy_engine
`default_nettype wire

// File: rtl/boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boot_ctrl
//  Description : Boot sequencer. Fetches from BIOS ROM after reset; on BIOS
//                hlt copies a length-prefixed image from HD into instruction
//                memory, pulses a CPU restart and switches fetch to the
//                loaded program. A later hlt parks the system in HALTED.
//  Revision    : 1.0  initial release
// ============================================================================
module boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned   HD_BASE    = c_hd_base_default,
  parameter int unsigned   IMEM_DEPTH = 1024,
  parameter int unsigned   AW         = 32
) (
  input  logic          clk_auto,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  input  logic          cpu_hlt,
  output logic [AW-1:0] bios_addr,
  input  logic [31:0]   bios_data,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  output logic [31:0]   instr,
  output logic          cpu_stall,
  output logic          cpu_restart,
  output logic          hd_req,
  output logic [AW-1:0] hd_addr,
  input  logic          hd_ack,
  input  logic [31:0]   hd_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic [2:0]    mode,
  output logic          load_err
);

  // Counter must hold IMEM_DEPTH itself, hence the extra bit.
  localparam int unsigned c_cw = $clog2(IMEM_DEPTH) + 1;

  boot_state_t r_state;
  logic        r_src_sel;
  logic        r_src_prev;
  logic        r_fetch_valid;
  logic        r_stall;
  logic        r_restart;
  logic        r_load_err;

  logic [AW-1:0]   w_len;
  logic            w_len_ok;
  logic            w_hdr_fetch;
  logic            w_hdr_ack;
  logic            w_start;
  logic            w_ack_ok;
  logic            w_eng_done;
  logic            w_busy;
  logic            w_done;
  logic            w_fetch_live;

  assign w_len       = hd_data[AW-1:0];
  assign w_len_ok    = (w_len != '0) && (w_len <= AW'(IMEM_DEPTH));
  assign w_hdr_fetch = (r_state == BOOT_BIOS) && cpu_hlt;
  assign w_hdr_ack   = (r_state == BOOT_HDR) && w_ack_ok;
  assign w_start     = w_hdr_ack && w_len_ok;
  assign w_done      = w_eng_done && w_busy;

  hd_copy_engine #(
    .AW      (AW),
    .CW      (c_cw),
    .HD_BASE (AW'(HD_BASE))
  ) u_copy (
    .clk_auto   (clk_auto),
    .reset_n    (reset_n),
    .hdr_fetch  (w_hdr_fetch),
    .start      (w_start),
    .len        (c_cw'(w_len)),
    .done       (w_eng_done),
    .busy       (w_busy),
    .ack_ok     (w_ack_ok),
    .hd_req     (hd_req),
    .hd_addr    (hd_addr),
    .hd_ack     (hd_ack),
    .hd_data    (hd_data),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  // Boot FSM with registered stall/restart/error outputs.
  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BOOT_BIOS;
      r_src_sel  <= SRC_BIOS;
      r_stall    <= 1'b0;
      r_restart  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      case (r_state)
        BOOT_BIOS: begin
          if (cpu_hlt) begin
            r_state <= BOOT_HDR;
            r_stall <= 1'b1;
          end
        end
        BOOT_HDR: begin
          if (w_hdr_ack) begin
            if (w_len_ok) begin
              r_state <= BOOT_COPY;
            end else begin
              r_state    <= BOOT_HALTED;
              r_load_err <= 1'b1;
            end
          end
        end
        BOOT_COPY: begin
          if (w_done) begin
            r_state   <= BOOT_RESTART;
            r_restart <= 1'b1;
          end
        end
        BOOT_RESTART: begin
          // Stall stays up for the first PROG cycle to cover fetch latency.
          r_restart <= 1'b0;
          r_src_sel <= SRC_PROG;
          r_stall   <= 1'b1;
          r_state   <= BOOT_PROG;
        end
        BOOT_PROG: begin
          if (cpu_hlt) begin
            r_state <= BOOT_HALTED;
            r_stall <= 1'b1;
          end else begin
            r_stall <= 1'b0;
          end
        end
        BOOT_HALTED: begin
          r_stall <= 1'b1;
        end
        default: begin
          r_state <= BOOT_BIOS;
        end
      endcase
    end
  end

  // Delay the source select and fetch qualifier to line up with the
  // one-cycle registered read of the ROM and instruction memory.
  always_ff @(posedge clk_auto or negedge reset_n) begin
    if (!reset_n) begin
      r_src_prev    <= SRC_BIOS;
      r_fetch_valid <= 1'b0;
    end else begin
      r_src_prev    <= r_src_sel;
      r_fetch_valid <= (r_state == BOOT_BIOS) || (r_state == BOOT_PROG);
    end
  end

  assign w_fetch_live = r_fetch_valid &&
                        ((r_state == BOOT_BIOS) || (r_state == BOOT_PROG));

  assign bios_addr   = pc;
  assign imem_addr   = pc;
  assign instr       = !w_fetch_live          ? 32'h0 :
                       (r_src_prev == SRC_PROG) ? imem_data : bios_data;
  assign cpu_stall   = r_stall;
  assign cpu_restart = r_restart;
  assign mode        = r_state;
  assign load_err    = r_load_err;

endmodule : boot_ctrl
`default_nettype wire

// File: tb/tb_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_ctrl
//  Description : Scoreboard bench for boot_ctrl. Stimulus pushes expected
//                imem writes into a queue; a monitor pops and compares them
//                and also watches restart pulses and the HD handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boot_ctrl;

  localparam int unsigned c_depth = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_auto;
  logic        reset_n;
  logic [31:0] pc;
  logic        cpu_hlt;
  logic [31:0] bios_addr;
  logic [31:0] bios_data;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        cpu_stall;
  logic        cpu_restart;
  logic        hd_req;
  logic [31:0] hd_addr;
  logic        hd_ack;
  logic [31:0] hd_data;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [2:0]  mode;
  logic        load_err;

  logic        resp_ack;
  logic        spur_ack;
  logic [31:0] resp_data;
  int          ack_delay;
  int          wait_cnt;
  logic        hold_chk;

  logic [31:0] hd_mem   [0:2047];
  logic [31:0] imem_m   [0:c_depth-1];
  wr_t         exp_q    [$];

  int total;
  int bad;
  int wr_cnt;
  int restart_cnt;

  assign hd_ack  = resp_ack | spur_ack;
  assign hd_data = resp_data;

  boot_ctrl #(
    .HD_BASE    (0),
    .IMEM_DEPTH (c_depth),
    .AW         (32)
  ) dut (
    .clk_auto    (clk_auto),
    .reset_n     (reset_n),
    .pc          (pc),
    .cpu_hlt     (cpu_hlt),
    .bios_addr   (bios_addr),
    .bios_data   (bios_data),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .cpu_stall   (cpu_stall),
    .cpu_restart (cpu_restart),
    .hd_req      (hd_req),
    .hd_addr     (hd_addr),
    .hd_ack      (hd_ack),
    .hd_data     (hd_data),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .mode        (mode),
    .load_err    (load_err)
  );

  initial clk_auto = 1'b0;
  always #5 clk_auto = ~clk_auto;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd3) return 32'h403E_FFFF;
    return 32'hB105_0000 ^ a;
  endfunction

  // BIOS ROM and instruction memory models, one-cycle registered reads.
  always @(posedge clk_auto) begin
    bios_data <= rom_word(bios_addr);
    if (imem_we) imem_m[imem_waddr[9:0]] <= imem_wdata;
    imem_data <= imem_m[imem_addr[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // HD responder: ack after ack_delay request cycles.
  initial begin
    resp_ack  = 1'b0;
    resp_data = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk_auto);
      #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (hd_req) begin
        if (wait_cnt + 1 >= ack_delay) begin
          resp_ack  = 1'b1;
          resp_data = hd_mem[hd_addr[10:0]];
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: write scoreboard, restart legality, handshake stability.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    wr_t         e;
    int          n;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk_auto);
      if (imem_we) begin
        wr_cnt++;
        chk("we_only_in_copy", 32'(mode), 32'd2);
        n = exp_q.size();
        chk("write_pending", 32'(n > 0), 32'd1);
        if (n > 0) begin
          e = exp_q.pop_front();
          chk("imem_waddr", imem_waddr, e.addr);
          chk("imem_wdata", imem_wdata, e.data);
        end
      end
      if (cpu_restart) begin
        restart_cnt++;
        chk("restart_only_in_restart", 32'(mode), 32'd3);
      end
      if (hold_chk && reset_n && prev_req) begin
        if (!prev_ack) begin
          chk("req_hold", 32'(hd_req), 32'd1);
          chk("addr_hold", hd_addr, prev_addr);
        end else begin
          chk("req_drop_after_ack", 32'(hd_req), 32'd0);
        end
      end
      prev_req  = hd_req;
      prev_ack  = hd_ack;
      prev_addr = hd_addr;
    end
  end

  task automatic pulse_hlt();
    @(negedge clk_auto);
    cpu_hlt = 1'b1;
    @(negedge clk_auto);
    cpu_hlt = 1'b0;
  endtask

  task automatic pulse_spur();
    @(posedge clk_auto);
    #1 spur_ack = 1'b1;
    @(posedge clk_auto);
    #1 spur_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_auto);
    reset_n = 1'b0;
    @(negedge clk_auto);
    reset_n = 1'b1;
    pc      = 32'd3;
  endtask

  task automatic wait_mode(input logic [2:0] m, input int bound);
    int i;
    i = 0;
    while (mode !== m && i < bound) begin
      @(negedge clk_auto);
      i++;
    end
    chk("wait_mode", 32'(mode), 32'(m));
  endtask

  // Header word plus n data words; expected writes go to the scoreboard.
  task automatic load_image(input logic [31:0] len, input int n, input logic [31:0] base);
    hd_mem[0] = len;
    for (int k = 0; k < n; k++) begin
      wr_t w;
      hd_mem[k + 1] = base | 32'(k);
      w.addr = 32'(k);
      w.data = base | 32'(k);
      exp_q.push_back(w);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    int i;
    total       = 0;
    bad         = 0;
    wr_cnt      = 0;
    restart_cnt = 0;
    reset_n     = 1'b0;
    pc          = '0;
    cpu_hlt     = 1'b0;
    spur_ack    = 1'b0;
    ack_delay   = 2;
    hold_chk    = 1'b0;
    for (int k = 0; k < 2048; k++) hd_mem[k] = '0;
    for (int k = 0; k < int'(c_depth); k++) imem_m[k] = '0;

    // Reset state.
    repeat (3) @(negedge clk_auto);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_hd_req", 32'(hd_req), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_restart", 32'(cpu_restart), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_hd_addr", hd_addr, 32'd0);
    chk("rst_imem_waddr", imem_waddr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    // BIOS fetch right after reset release.
    reset_n = 1'b1;
    pc      = 32'd3;
    @(negedge clk_auto);
    chk("bios_instr", instr, 32'h403E_FFFF);
    chk("bios_stall", 32'(cpu_stall), 32'd0);
    chk("bios_mode", 32'(mode), 32'd0);

    // Basic 3-word load.
    hd_mem[0] = 32'd3;
    hd_mem[1] = 32'h11;
    hd_mem[2] = 32'h22;
    hd_mem[3] = 32'h33;
    exp_q.push_back('{32'd0, 32'h11});
    exp_q.push_back('{32'd1, 32'h22});
    exp_q.push_back('{32'd2, 32'h33});
    pc = 32'd1;
    r0 = restart_cnt;
    pulse_hlt();
    chk("hdr_mode", 32'(mode), 32'd1);
    chk("hdr_stall", 32'(cpu_stall), 32'd1);
    chk("hdr_addr", hd_addr, 32'd0);
    wait_mode(3'd4, 200);
    chk("prog_entry_stall", 32'(cpu_stall), 32'd1);
    chk("restart_pulses", 32'(restart_cnt - r0), 32'd1);
    chk("basic_writes_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk_auto);
    chk("prog_stall_released", 32'(cpu_stall), 32'd0);
    chk("prog_instr", instr, 32'h22);

    // hlt in PROG parks in HALTED; further hlt/ack are ignored.
    pulse_hlt();
    chk("halt_mode", 32'(mode), 32'd5);
    chk("halt_stall", 32'(cpu_stall), 32'd1);
    chk("halt_instr", instr, 32'd0);
    pulse_spur();
    pulse_hlt();
    repeat (4) @(negedge clk_auto);
    chk("halt_stays", 32'(mode), 32'd5);
    chk("halt_no_req", 32'(hd_req), 32'd0);
    chk("halt_no_err", 32'(load_err), 32'd0);

    // Bad header: zero length.
    do_reset();
    load_image(32'd0, 0, 32'h0);
    pulse_hlt();
    wait_mode(3'd5, 50);
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_stall", 32'(cpu_stall), 32'd1);

    // Bad header: one word too long.
    do_reset();
    chk("load_err_cleared", 32'(load_err), 32'd0);
    load_image(c_depth + 1, 0, 32'h0);
    pulse_hlt();
    wait_mode(3'd5, 50);
    chk("len_over_err", 32'(load_err), 32'd1);

    // Slow HD with stability checks and a spurious ack in BIOS.
    do_reset();
    w0 = wr_cnt;
    pulse_spur();
    repeat (2) @(negedge clk_auto);
    chk("spurious_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("spurious_mode", 32'(mode), 32'd0);
    hold_chk  = 1'b1;
    ack_delay = 10;
    load_image(32'd2, 2, 32'hA5A5_0000);
    pulse_hlt();
    wait_mode(3'd4, 300);
    chk("slow_writes_done", 32'(exp_q.size()), 32'd0);
    hold_chk  = 1'b0;

    // Maximum legal length.
    do_reset();
    ack_delay = 1;
    load_image(c_depth, int'(c_depth), 32'hC0DE_0000);
    pc = 32'd1023;
    r0 = restart_cnt;
    pulse_hlt();
    wait_mode(3'd4, 5000);
    chk("full_writes_done", 32'(exp_q.size()), 32'd0);
    chk("full_restart", 32'(restart_cnt - r0), 32'd1);
    @(negedge clk_auto);
    chk("full_last_word", instr, 32'hC0DE_03FF);

    // Reset after 2 of 5 writes.
    do_reset();
    ack_delay = 2;
    load_image(32'd5, 5, 32'h5EED_0000);
    w0 = wr_cnt;
    pulse_hlt();
    i = 0;
    while ((wr_cnt - w0) < 2 && i < 100) begin
      @(posedge clk_auto);
      i++;
    end
    chk("midcopy_two_writes", 32'(wr_cnt - w0), 32'd2);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_hd_req", 32'(hd_req), 32'd0);
    chk("midrst_imem_we", 32'(imem_we), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_stall", 32'(cpu_stall), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_hd_addr", hd_addr, 32'd0);
    chk("midrst_waddr", imem_waddr, 32'd0);
    @(negedge clk_auto);
    reset_n = 1'b1;
    pc      = 32'd3;
    @(negedge clk_auto);
    chk("midrst_bios_instr", instr, 32'h403E_FFFF);
    chk("midrst_bios_mode", 32'(mode), 32'd0);
    repeat (10) @(negedge clk_auto);
    chk("midrst_no_more_writes", 32'(wr_cnt - w0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_boot_ctrl
`default_nettype wire

// File: doc/boot_ctrl.md
Name: boot_ctrl

Overview:
- Boot sequencer between the CPU fetch port, the BIOS ROM, the hard disk and instruction memory.
- After reset the CPU fetches from the BIOS ROM.
- On BIOS hlt, the block copies a length-prefixed program image from HD into instruction memory, pulses a CPU restart and switches fetch to instruction memory.
- A later hlt parks the system in HALTED.

Parameters:
- HD_BASE, 0, HD word address of the image header (word = program length in words).
- IMEM_DEPTH, 1024, instruction memory size in words; maximum legal program length.
- AW, 32, address width of all address ports.

Ports:
- clk_auto  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- pc  in  AW  CPU program counter.
- cpu_hlt  in  1  one-cycle pulse when the CPU retires hlt.
- bios_addr  out  AW  BIOS ROM address (ROM has 1-cycle registered read).
- bios_data  in  32  BIOS ROM read data.
- imem_addr  out  AW  instruction memory read address (1-cycle registered read).
- imem_data  in  32  instruction memory read data.
- instr  out  32  instruction delivered to the CPU.
- cpu_stall  out  1  CPU must hold pc and not commit.
- cpu_restart  out  1  one-cycle pulse: CPU resets pc to 0.
- hd_req  out  1  HD read request.
- hd_addr  out  AW  HD word address.
- hd_ack  in  1  HD read done; hd_data is valid in this cycle.
- hd_data  in  32  HD read data.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  AW  instruction memory write address.
- imem_wdata  out  32  instruction memory write data.
- mode  out  3  current state encoding.
- load_err  out  1  sticky flag: bad image length.

Behaviour:
- States, with mode encoding:
  - BIOS=0
  - HDR=1
  - COPY=2
  - RESTART=3
  - PROG=4
  - HALTED=5
- Reset (async, reset_n=0) forces state BIOS and these output values:
  - counter=0, src_sel=BIOS, load_err=0.
  - hd_req=0, imem_we=0, cpu_restart=0, cpu_stall=0.
  - instr=0, hd_addr=0, imem_waddr=0, imem_wdata=0.
- Reset mid-COPY abandons the copy: no further imem_we, and hd_req drops immediately.
- Fetch path:
  - bios_addr=pc and imem_addr=pc, combinationally.
  - src_sel is a register updated on state change.
  - instr = bios_data when the previous-cycle src_sel is BIOS, imem_data when it is PROG. This matches the 1-cycle ROM/RAM latency.
  - instr=0 in HDR, COPY, RESTART and HALTED.
- cpu_stall:
  - High in HDR, COPY, RESTART and HALTED.
  - High for exactly one cycle on entry to PROG, to cover memory latency.
- BIOS:
  - cpu_hlt → HDR.
  - Same cycle: hd_addr=HD_BASE, hd_req=1.
- hd_req handshake:
  - hd_req stays high with hd_addr stable until the cycle hd_ack=1.
  - hd_req drops the following cycle.
  - hd_ack while hd_req=0 is ignored.
- HDR, on hd_ack:
  - len=hd_data[AW-1:0].
  - len==0 or len>IMEM_DEPTH → load_err=1, go to HALTED.
  - Otherwise counter=0, go to COPY, issue request at HD_BASE+1.
- COPY, on each hd_ack:
  - Next cycle: imem_we=1, imem_waddr=counter, imem_wdata=registered hd_data; counter increments.
  - While counter+1<len, the next request is issued in the same cycle as the write, at HD_BASE+2+counter. This gives 1 idle cycle min between req pulses.
  - The write with counter==len-1 → RESTART.
- RESTART:
  - cpu_restart=1 for exactly one cycle, src_sel=PROG, then → PROG.
- PROG:
  - cpu_hlt → HALTED.
- HALTED:
  - Terminal; leaves only via reset.
  - cpu_hlt is ignored in every state other than BIOS and PROG.
- Address arithmetic is AW-bit and wraps modulo 2^AW. The counter is clog2(IMEM_DEPTH)+1 bits, so len==IMEM_DEPTH is legal.
- imem_we is never asserted outside COPY.
- cpu_restart is never asserted outside RESTART.

Decomposition:
- Shared package boot_pkg holds:
  - state enum BOOT_BIOS..BOOT_HALTED with the mode encodings.
  - src_sel constants SRC_BIOS and SRC_PROG.
  - the HD_BASE default.
- One natural sub-module: hd_copy_engine. It owns the req/ack handshake, the counter and the write strobe, with ports start, len, done and busy. The top keeps the FSM and the fetch mux.

Test Plan:
- Fetch after reset: release reset, pc=3, BIOS word 3=0x403EFFFF → instr=0x403EFFFF one cycle later; cpu_stall=0; mode=0.
- Basic load:
  - HD image len=3, words 0x11, 0x22, 0x33; cpu_hlt pulse; hd_ack 2 cycles after each req.
  - Expect writes imem[0..2]=0x11, 0x22, 0x33 in order.
  - Then one cpu_restart pulse, mode=4, and stall for exactly one cycle after entering PROG.
- Handshake holding: hd_ack delayed 10 cycles → hd_req and hd_addr stable throughout; a spurious hd_ack with hd_req=0 causes no write.
- Bad header:
  - len=0 → load_err=1, mode=5, no imem_we.
  - Repeat with len=IMEM_DEPTH+1 → same result.
  - len=IMEM_DEPTH → completes with IMEM_DEPTH writes.
- Reset mid-COPY: assert reset_n=0 after 2 of 5 writes → outputs at reset values immediately; after release mode=0 and the BIOS fetch works.
- HALTED and hlt filtering: cpu_hlt in PROG → mode=5, stall=1; further cpu_hlt and hd_ack pulses change nothing.
